// File: rtl/npc_pc_reg_pkg.sv
// Shared definitions for the fetch-stage PC/next-PC block: redirect codes,
// FSM state encoding, reset defaults and the PC increment helper.
package npc_pc_reg_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;
  localparam logic [31:0] DEFAULT_IM_BYTES = 32'h0000_1000;
  localparam logic [31:0] PC_STEP          = 32'd4;

  typedef enum logic [1:0] {
    REDIR_NONE = 2'b00,
    REDIR_BR   = 2'b01,
    REDIR_J    = 2'b10,
    REDIR_JR   = 2'b11
  } redir_sel_e;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_PEND = 1'b1
  } npc_state_e;

  // Sequential fetch address; wraps modulo 2^32.
  function automatic logic [31:0] pc_plus4(input logic [31:0] addr);
    return addr + PC_STEP;
  endfunction

endpackage

// File: rtl/npc_target.sv
// Combinational redirect target: branch adder, j/jal region splice, jr/jalr pass-through.
module npc_target
  import npc_pc_reg_pkg::*;
(
  input  logic [1:0]  redir_sel,
  input  logic [31:0] d_pc4,
  input  logic [31:0] yi32,
  input  logic [25:0] j_index,
  input  logic [31:0] jr_target,
  output logic [31:0] tgt,
  output logic        has_tgt
);

  redir_sel_e sel;

  assign sel = redir_sel_e'(redir_sel);

  always_comb begin
    tgt     = '0;
    has_tgt = 1'b1;
    unique case (sel)
      REDIR_BR:   tgt = d_pc4 + yi32;
      // Jump stays inside the 256 MB region of the delay-slot instruction.
      REDIR_J:    tgt = {d_pc4[31:28], j_index, 2'b00};
      REDIR_JR:   tgt = jr_target;
      default:    has_tgt = 1'b0;
    endcase
  end

endmodule

// File: rtl/npc_pc_reg.sv
// Fetch PC register with stall hold and one-deep redirect buffer (RUN/PEND FSM).
// Optional fetch address check enabled by defining PC_CHECK_EN.
module npc_pc_reg
  import npc_pc_reg_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [31:0] IM_BYTES = DEFAULT_IM_BYTES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redir_vld,
  input  logic [1:0]  redir_sel,
  input  logic [31:0] d_pc4,
  input  logic [31:0] yi32,
  input  logic [25:0] j_index,
  input  logic [31:0] jr_target,
  output logic [31:0] pc,
  output logic [31:0] pc4,
  output logic        pend,
  output logic        adel_f
);

  if (IM_BYTES == 32'd0 || IM_BYTES[1:0] != 2'b00) begin : g_bad_im_bytes
    $error("npc_pc_reg: IM_BYTES must be a non-zero multiple of 4");
  end

  npc_state_e  state, state_nxt;
  logic [31:0] pend_tgt, pend_tgt_nxt;
  logic [31:0] pc_nxt;
  logic [31:0] tgt;
  logic        has_tgt;
  logic        redir;

  npc_target u_target (
    .redir_sel (redir_sel),
    .d_pc4     (d_pc4),
    .yi32      (yi32),
    .j_index   (j_index),
    .jr_target (jr_target),
    .tgt       (tgt),
    .has_tgt   (has_tgt)
  );

  // A pulse carrying code 00 is not a control transfer at all.
  assign redir = redir_vld & has_tgt;

  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    pend_tgt_nxt = pend_tgt;
    unique case (state)
      ST_RUN: begin
        if (!stall) begin
          pc_nxt = redir ? tgt : pc_plus4(pc);
        end else if (redir) begin
          pend_tgt_nxt = tgt;
          state_nxt    = ST_PEND;
        end
      end
      ST_PEND: begin
        if (stall) begin
          if (redir) pend_tgt_nxt = tgt;
        end else begin
          // A fresh redirect on release is younger than the buffered one.
          pc_nxt    = redir ? tgt : pend_tgt;
          state_nxt = ST_RUN;
        end
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_RUN;
      pc       <= RESET_PC;
      pend_tgt <= '0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      pend_tgt <= pend_tgt_nxt;
    end
  end

  assign pc4  = pc_plus4(pc);
  assign pend = (state == ST_PEND);

`ifdef PC_CHECK_EN
  // Offset compare avoids overflow of RESET_PC + IM_BYTES near the top of memory.
  function automatic logic addr_bad(input logic [31:0] addr);
    logic [31:0] ofs;
    ofs = addr - RESET_PC;
    return (addr[1:0] != 2'b00) || (addr < RESET_PC) || (ofs >= IM_BYTES);
  endfunction

  logic adel_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) adel_q <= 1'b0;
    else        adel_q <= addr_bad(pc_nxt);
  end

  assign adel_f = adel_q;
`else
  assign adel_f = 1'b0;
`endif

endmodule
